// File: rtl/cordic_vectoring.sv
// Purpose: 6-step iterative vectoring CORDIC, (x, y) -> gain-scaled magnitude and binary angle atan2(y, x).
// Latency: request accepted at edge k, results and one-cycle valid strobe at edge k+6, idle again at k+7.
// Backpressure: none; requests arriving while busy_o is high are dropped silently, minimum period 8 cycles.
module cordic_vectoring #(
    parameter int N_FRAC = 7
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic signed [N_FRAC:0]   x_i,
    input  logic signed [N_FRAC:0]   y_i,
    input  logic                     data_in_valid_strobe_i,
    output logic        [N_FRAC+1:0] mag_o,
    output logic signed [N_FRAC:0]   angle_o,
    output logic                     data_out_valid_strobe_o,
    output logic                     busy_o
);

    // Two guard bits on x/y: one so that negating -2^N_FRAC fits, one for the CORDIC gain.
    localparam int XW = N_FRAC + 3;
    localparam int ZW = N_FRAC + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [2:0]           cnt_q;
    logic signed [XW-1:0] x_q;
    logic signed [XW-1:0] y_q;
    logic signed [ZW-1:0] z_q;
    logic                 zero_q;

    logic signed [XW-1:0] x_ext;
    logic signed [XW-1:0] y_ext;
    logic signed [XW-1:0] pre_x;
    logic signed [XW-1:0] pre_y;
    logic signed [ZW-1:0] pre_z;
    logic signed [XW-1:0] x_nx;
    logic signed [XW-1:0] y_nx;
    logic signed [ZW-1:0] z_nx;
    logic signed [ZW-1:0] atan_step;
    logic                 accept;
    logic                 last_iter;

    // atan(2^-i) in units of pi/128.
    function automatic logic signed [ZW-1:0] atan_lut(input logic [2:0] idx);
        case (idx)
            3'd0:    atan_lut = ZW'(32);
            3'd1:    atan_lut = ZW'(18);
            3'd2:    atan_lut = ZW'(9);
            3'd3:    atan_lut = ZW'(5);
            3'd4:    atan_lut = ZW'(2);
            3'd5:    atan_lut = ZW'(1);
            default: atan_lut = ZW'(0);
        endcase
    endfunction

    assign accept    = (state_q == IDLE) && data_in_valid_strobe_i;
    assign last_iter = (cnt_q == 3'd5);
    assign x_ext     = {{2{x_i[N_FRAC]}}, x_i};
    assign y_ext     = {{2{y_i[N_FRAC]}}, y_i};
    assign atan_step = atan_lut(cnt_q);

    // Quadrant pre-rotation by +/-90 degrees so the micro-rotations only need to cover the right half-plane.
    always_comb begin
        pre_x = x_ext;
        pre_y = y_ext;
        pre_z = '0;
        if (x_i[N_FRAC]) begin
            if (!y_i[N_FRAC]) begin
                pre_x = y_ext;
                pre_y = -x_ext;
                pre_z = ZW'(64);
            end else begin
                pre_x = -y_ext;
                pre_y = x_ext;
                pre_z = -ZW'(64);
            end
        end
    end

    // One micro-rotation driving y toward zero; both updates use the pre-update x and y.
    always_comb begin
        x_nx = x_q + (y_q >>> cnt_q);
        y_nx = y_q - (x_q >>> cnt_q);
        z_nx = z_q + atan_step;
        if (y_q[XW-1]) begin
            x_nx = x_q - (y_q >>> cnt_q);
            y_nx = y_q + (x_q >>> cnt_q);
            z_nx = z_q - atan_step;
        end
    end

    // Next-state logic; any unused encoding falls back to IDLE.
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = accept ? CALC : IDLE;
            CALC:    state_d = last_iter ? OUTPUT : CALC;
            OUTPUT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Working registers and result registers; results only change on the final iteration.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            zero_q  <= 1'b0;
            mag_o   <= '0;
            angle_o <= '0;
        end else begin
            if (accept) begin
                cnt_q  <= '0;
                x_q    <= pre_x;
                y_q    <= pre_y;
                z_q    <= pre_z;
                zero_q <= (x_i == '0) && (y_i == '0);
            end else if (state_q == CALC) begin
                x_q <= x_nx;
                y_q <= y_nx;
                z_q <= z_nx;
                if (last_iter) begin
                    mag_o   <= zero_q ? '0 : x_nx[N_FRAC+1:0];
                    angle_o <= zero_q ? '0 : z_nx;
                end else begin
                    cnt_q <= cnt_q + 3'd1;
                end
            end
        end
    end

    assign data_out_valid_strobe_o = (state_q == OUTPUT);
    assign busy_o                  = (state_q != IDLE);

endmodule

// File: tb/tb_cordic_vectoring.sv
module tb_cordic_vectoring;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic signed [7:0] x_i;
    logic signed [7:0] y_i;
    logic              data_in_valid_strobe_i;
    logic        [8:0] mag_o;
    logic signed [7:0] angle_o;
    logic              data_out_valid_strobe_o;
    logic              busy_o;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    cordic_vectoring #(.N_FRAC(7)) dut (
        .clk_i                   (clk_i),
        .rst_i                   (rst_i),
        .x_i                     (x_i),
        .y_i                     (y_i),
        .data_in_valid_strobe_i  (data_in_valid_strobe_i),
        .mag_o                   (mag_o),
        .angle_o                 (angle_o),
        .data_out_valid_strobe_o (data_out_valid_strobe_o),
        .busy_o                  (busy_o)
    );

    // Floor division by 2^s on plain integers.
    function automatic int fdiv(input int v, input int s);
        int d;
        d = 1 << s;
        if (v >= 0) return v / d;
        return -((-v + d - 1) / d);
    endfunction

    // Reference: quadrant fold, six greedy micro-rotations, angle reduced modulo 256 at the end.
    task automatic model(input int xv, input int yv, output int m, output int a);
        int xx, yy, zz, dx, dy;
        int tbl [6];
        tbl = '{32, 18, 9, 5, 2, 1};
        if (xv >= 0)      begin xx = xv;  yy = yv;  zz = 0;   end
        else if (yv >= 0) begin xx = yv;  yy = -xv; zz = 64;  end
        else              begin xx = -yv; yy = xv;  zz = -64; end
        for (int i = 0; i < 6; i++) begin
            dx = fdiv(yy, i);
            dy = fdiv(xx, i);
            if (yy >= 0) begin xx = xx + dx; yy = yy - dy; zz = zz + tbl[i]; end
            else         begin xx = xx - dx; yy = yy + dy; zz = zz - tbl[i]; end
        end
        zz = ((zz % 256) + 256) % 256;
        if (zz > 127) zz = zz - 256;
        m = xx;
        a = zz;
        if (xv == 0 && yv == 0) begin m = 0; a = 0; end
    endtask

    // Called at a falling edge; holds the request across one rising edge, then scrambles the data inputs.
    task automatic start_req(input int xv, input int yv);
        x_i = 8'(xv);
        y_i = 8'(yv);
        data_in_valid_strobe_i = 1'b1;
        @(posedge clk_i);
        #1;
        data_in_valid_strobe_i = 1'b0;
        x_i = 8'($urandom);
        y_i = 8'($urandom);
    endtask

    // Waits (bounded) for the output strobe; lat is the falling-edge index after accept, -1 on timeout.
    task automatic wait_done(output int lat, output int m, output int a, output int busy_gap);
        lat = -1; m = -1; a = -999; busy_gap = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk_i);
            if (busy_o !== 1'b1) busy_gap++;
            if (data_out_valid_strobe_o === 1'b1) begin
                lat = c;
                m   = int'(mag_o);
                a   = int'(angle_o);
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        data_in_valid_strobe_i = 1'b0;
        x_i = '0;
        y_i = '0;
        #12;
        total++; if (mag_o !== 9'd0) begin bad++; $display("FAIL reset_mag: got %0d want 0", mag_o); end
        total++; if (angle_o !== 8'sd0) begin bad++; $display("FAIL reset_angle: got %0d want 0", angle_o); end
        total++; if (data_out_valid_strobe_o !== 1'b0) begin bad++; $display("FAIL reset_strobe: got %b want 0", data_out_valid_strobe_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    task automatic test_directed();
        int vx [4], vy [4], em [4], ea [4];
        int lat, m, a, gap;
        vx = '{100, 0, -128, 0};
        vy = '{0, 100, 0, 0};
        em = '{166, 164, 211, 0};
        ea = '{1, 63, 127, 0};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            start_req(vx[i], vy[i]);
            wait_done(lat, m, a, gap);
            total++; if (lat != 6) begin bad++; $display("FAIL dir%0d_latency: got %0d want 6", i, lat); end
            total++; if (m != em[i]) begin bad++; $display("FAIL dir%0d_mag: got %0d want %0d", i, m, em[i]); end
            total++; if (a != ea[i]) begin bad++; $display("FAIL dir%0d_angle: got %0d want %0d", i, a, ea[i]); end
            total++; if (gap != 0) begin bad++; $display("FAIL dir%0d_busy: got %0d idle cycles want 0", i, gap); end
        end
    endtask

    task automatic test_random();
        int cx [4], cy [4];
        int xv, yv, em, ea, lat, m, a, gap;
        cx = '{-128, 127, -128, 127};
        cy = '{-128, 127, 127, -128};
        for (int i = 0; i < 40; i++) begin
            if (i < 4) begin xv = cx[i]; yv = cy[i]; end
            else begin
                xv = int'($urandom_range(255)) - 128;
                yv = int'($urandom_range(255)) - 128;
            end
            model(xv, yv, em, ea);
            @(negedge clk_i);
            start_req(xv, yv);
            wait_done(lat, m, a, gap);
            total++; if (lat != 6) begin bad++; $display("FAIL rnd_latency (%0d,%0d): got %0d want 6", xv, yv, lat); end
            total++; if (m != em) begin bad++; $display("FAIL rnd_mag (%0d,%0d): got %0d want %0d", xv, yv, m, em); end
            total++; if (a != ea) begin bad++; $display("FAIL rnd_angle (%0d,%0d): got %0d want %0d", xv, yv, a, ea); end
            if (i == 39) begin
                repeat (4) @(negedge clk_i);
                total++; if (int'(mag_o) != em) begin bad++; $display("FAIL hold_mag: got %0d want %0d", mag_o, em); end
                total++; if (int'(angle_o) != ea) begin bad++; $display("FAIL hold_angle: got %0d want %0d", angle_o, ea); end
            end
        end
    endtask

    task automatic test_busy_ignore();
        int nstrobe = 0;
        int first = -1;
        int m = -1;
        int a = -999;
        @(negedge clk_i);
        start_req(100, 0);
        repeat (3) @(negedge clk_i);
        x_i = 8'sd0;
        y_i = 8'sd100;
        data_in_valid_strobe_i = 1'b1;
        @(posedge clk_i);
        #1;
        data_in_valid_strobe_i = 1'b0;
        for (int c = 3; c < 20; c++) begin
            @(negedge clk_i);
            if (data_out_valid_strobe_o === 1'b1) begin
                nstrobe++;
                if (first < 0) begin first = c; m = int'(mag_o); a = int'(angle_o); end
            end
        end
        total++; if (nstrobe != 1) begin bad++; $display("FAIL busy_strobe_count: got %0d want 1", nstrobe); end
        total++; if (first != 6) begin bad++; $display("FAIL busy_latency: got %0d want 6", first); end
        total++; if (m != 166) begin bad++; $display("FAIL busy_mag: got %0d want 166", m); end
        total++; if (a != 1) begin bad++; $display("FAIL busy_angle: got %0d want 1", a); end
    endtask

    task automatic test_back_to_back();
        int lat, m, a, gap;
        @(negedge clk_i);
        start_req(100, 0);
        wait_done(lat, m, a, gap);
        total++; if (lat != 6 || m != 166 || a != 1) begin bad++; $display("FAIL b2b_first: got lat=%0d %0d/%0d want lat=6 166/1", lat, m, a); end
        @(negedge clk_i);
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL b2b_idle_busy: got %b want 0", busy_o); end
        start_req(0, 100);
        wait_done(lat, m, a, gap);
        total++; if (lat != 6) begin bad++; $display("FAIL b2b_latency: got %0d want 6", lat); end
        total++; if (m != 164) begin bad++; $display("FAIL b2b_mag: got %0d want 164", m); end
        total++; if (a != 63) begin bad++; $display("FAIL b2b_angle: got %0d want 63", a); end
    endtask

    task automatic test_reset_mid();
        int lat, m, a, gap;
        int seen = 0;
        @(negedge clk_i);
        start_req(100, 0);
        repeat (3) @(negedge clk_i);
        @(posedge clk_i);
        #2;
        rst_i = 1'b0;
        #1;
        total++; if (mag_o !== 9'd0) begin bad++; $display("FAIL rstmid_mag: got %0d want 0", mag_o); end
        total++; if (angle_o !== 8'sd0) begin bad++; $display("FAIL rstmid_angle: got %0d want 0", angle_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", busy_o); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            if (data_out_valid_strobe_o !== 1'b0) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL rstmid_strobe: got %0d strobes want 0", seen); end
        rst_i = 1'b1;
        start_req(0, 100);
        wait_done(lat, m, a, gap);
        total++; if (lat != 6) begin bad++; $display("FAIL rstmid_latency: got %0d want 6", lat); end
        total++; if (m != 164) begin bad++; $display("FAIL rstmid_mag_after: got %0d want 164", m); end
        total++; if (a != 63) begin bad++; $display("FAIL rstmid_angle_after: got %0d want 63", a); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
